rs_add: RTL and testbench
=========================

Name: rs_add

Overview:
- Reservation station / issue queue feeding the add execution unit; the initiator side of the add-unit issue interface.
- Buffers renamed add instructions from dispatch and captures operand values from the result broadcast bus (CDB).
- Each cycle, selects the oldest entry with both operands ready and drives valid_add/Pw_add/busA_add/busB_add/tag_ROB_add into the add unit through registered outputs.

Parameters:
- DEPTH, 4, number of entries (2..8).
- DATA_W, 16, operand/result width.
- PREG_W, 5, physical register tag width.
- ROB_W, 4, ROB tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (rst=0 resets).
- flush  in  1  synchronous squash of all entries and the issue register.
- freeze_back  in  1  back-end stall; blocks issue and holds the issue register.
- valid_dispatch  in  1  dispatch request.
- Pw_dispatch  in  PREG_W  destination physical register.
- Pa_dispatch, Pb_dispatch  in  PREG_W  source tags.
- rdyA_dispatch, rdyB_dispatch  in  1  source value already available.
- valA_dispatch, valB_dispatch  in  DATA_W  source values (meaningful when rdy=1).
- tag_ROB_dispatch  in  ROB_W  ROB tag.
- full_rs  out  1  count==DEPTH (registered state); dispatch is ignored when high.
- valid_cdb  in  1  broadcast valid.
- Pw_cdb  in  PREG_W  broadcast tag.
- data_cdb  in  DATA_W  broadcast value.
- valid_add  out  1  issue valid to the add unit.
- Pw_add  out  PREG_W  issued destination.
- busA_add, busB_add  out  DATA_W  issued operands.
- tag_ROB_add  out  ROB_W  issued ROB tag.

Behaviour:
- Reset (rst=0, async): all entries invalid; count=0; full_rs=0; valid_add=0; Pw_add, busA_add, busB_add, tag_ROB_add = 0.
- Storage: compacting queue. Entry 0 is oldest. Per entry: v, Pw, Pa, Pb, rdyA, rdyB, valA, valB, tag.
- Dispatch: accepted iff valid_dispatch & !full_rs & !flush. Written at the lowest free index after compaction for the same-cycle issue.
- Dispatch/CDB bypass: if valid_cdb and Pw_cdb matches a dispatching not-ready source tag, that source is written as ready with data_cdb.
- Wakeup: every valid entry with a not-ready source matching Pw_cdb (valid_cdb=1) sets rdy and latches data_cdb. Wakeup still occurs while freeze_back=1.
- Select: the lowest-index entry with v & rdyA & rdyB, only when !freeze_back & !flush.
- Issue on select at the edge:
  - Issue register loads that entry: valid_add=1, Pw_add=Pw, busA_add=valA, busB_add=valB, tag_ROB_add=tag.
  - The entry is removed and higher entries shift down one.
- No select and !freeze_back: valid_add=0 next cycle; the other output fields hold.
- freeze_back=1: issue register holds all values, including valid_add; no entry is removed.
- Latency: dispatch with both sources ready in cycle N → entry present in N+1 → valid_add=1 in N+2. Woken in cycle N (registered) → eligible in N+1.
- Throughput: one issue per cycle.
- Counting: count += accepted_dispatch − issued. With the queue full, an issue in cycle N frees a slot, but dispatch is accepted only from N+1 (full_rs is registered).
- flush: all entries invalid, count=0, valid_add=0 at the next edge. flush dominates freeze_back and dispatch.
- Reset mid-operation: immediate clear, regardless of clock.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined: an entry whose last missing operand is woken by the CDB in cycle N is selectable in cycle N. The issued operand is muxed from data_cdb, so wakeup-to-issue is 1 cycle (valid_add in N+1).
- Undefined: the woken entry is selectable only from cycle N+1 (valid_add in N+2).

Test Plan:
- Reset then dispatch {Pw=3, rdyA=rdyB=1, valA=0x0010, valB=0x0020, tag=2} in cycle 1 → cycle 3: valid_add=1, busA_add=0x0010, busB_add=0x0020, Pw_add=3, tag_ROB_add=2; cycle 4: valid_add=0.
- Dispatch {Pa=7 not ready, tag=1}, then {ready, tag=2}; CDB Pw=7, data=0x1234 three cycles later:
  - tag 2 issues first.
  - tag 1 issues 2 cycles after the CDB (1 cycle if RS_WAKEUP_BYPASS_EN), with busA_add=0x1234.
- Fill 4 not-ready entries → full_rs=1; a 5th dispatch is dropped. Wake one entry → it issues; full_rs=0 the next cycle; the next dispatch is accepted.
- Two ready entries with freeze_back=1 for 3 cycles:
  - valid_add and fields hold; no entries are removed.
  - After release, the oldest entry issues first.
- Dispatch with Pa matching same-cycle CDB Pw=9, data=0xBEEF → entry stored ready; issues with busA_add=0xBEEF.
- 3 entries plus a valid issue register; assert flush → next cycle valid_add=0, full_rs=0, and no further issues without new dispatch.

Source files
------------

// File: rtl/rs_add.sv
// rs_add: reservation station (issue queue) for the add execution unit.
//
// Renamed add instructions are buffered in a compacting queue (entry 0 is
// the oldest). Missing operands are captured from the result broadcast bus
// (CDB). Each cycle the oldest entry with both operands ready is issued
// through a registered interface into the add unit.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   defined   : an entry whose last missing operand arrives on the CDB in
//               cycle N can be selected in cycle N. Its operand is taken
//               from data_cdb, so valid_add rises in N+1.
//   undefined : a woken entry becomes selectable in N+1 (valid_add in N+2).

module rs_add #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int PREG_W = 5,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze_back,
    // dispatch side
    input  logic              valid_dispatch,
    input  logic [PREG_W-1:0] Pw_dispatch,
    input  logic [PREG_W-1:0] Pa_dispatch,
    input  logic [PREG_W-1:0] Pb_dispatch,
    input  logic              rdyA_dispatch,
    input  logic              rdyB_dispatch,
    input  logic [DATA_W-1:0] valA_dispatch,
    input  logic [DATA_W-1:0] valB_dispatch,
    input  logic [ROB_W-1:0]  tag_ROB_dispatch,
    output logic              full_rs,
    // result broadcast bus
    input  logic              valid_cdb,
    input  logic [PREG_W-1:0] Pw_cdb,
    input  logic [DATA_W-1:0] data_cdb,
    // issue interface into the add unit
    output logic              valid_add,
    output logic [PREG_W-1:0] Pw_add,
    output logic [DATA_W-1:0] busA_add,
    output logic [DATA_W-1:0] busB_add,
    output logic [ROB_W-1:0]  tag_ROB_add
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PREG_W-1:0] pw;
        logic [PREG_W-1:0] pa;
        logic [PREG_W-1:0] pb;
        logic              rdy_a;
        logic              rdy_b;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [ROB_W-1:0]  tag;
    } entry_t;

    // Registered queue state: valid bits and occupancy are reset, payload is not.
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Combinational views
    entry_t           wk [DEPTH];     // entries after this cycle's CDB wakeup
    entry_t           disp_ent;       // incoming entry after CDB bypass
    logic [DEPTH-1:0] cand;           // entries eligible for selection
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    entry_t           sel_ent;
    logic             accept;
    logic [CNT_W-1:0] wr_idx;

    assign full_rs = (count_q == CNT_W'(DEPTH));
    assign accept  = valid_dispatch & ~full_rs & ~flush;

    // Wakeup: capture the CDB value into every waiting source whose tag matches.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            // NOTE: every combinational output gets a default before any
            // conditional override, so no path leaves it unassigned (no latch).
            wk[i] = ent_q[i];
            if (v_q[i] && valid_cdb) begin
                if (!ent_q[i].rdy_a && (ent_q[i].pa == Pw_cdb)) begin
                    wk[i].rdy_a = 1'b1;
                    wk[i].val_a = data_cdb;
                end
                if (!ent_q[i].rdy_b && (ent_q[i].pb == Pw_cdb)) begin
                    wk[i].rdy_b = 1'b1;
                    wk[i].val_b = data_cdb;
                end
            end
        end
    end

    // Dispatch entry build, with same-cycle CDB bypass into not-ready sources.
    always_comb begin
        disp_ent.pw    = Pw_dispatch;
        disp_ent.pa    = Pa_dispatch;
        disp_ent.pb    = Pb_dispatch;
        disp_ent.rdy_a = rdyA_dispatch;
        disp_ent.rdy_b = rdyB_dispatch;
        disp_ent.val_a = valA_dispatch;
        disp_ent.val_b = valB_dispatch;
        disp_ent.tag   = tag_ROB_dispatch;
        if (valid_cdb && !rdyA_dispatch && (Pa_dispatch == Pw_cdb)) begin
            disp_ent.rdy_a = 1'b1;
            disp_ent.val_a = data_cdb;
        end
        if (valid_cdb && !rdyB_dispatch && (Pb_dispatch == Pw_cdb)) begin
            disp_ent.rdy_b = 1'b1;
            disp_ent.val_b = data_cdb;
        end
    end

    // Select: oldest (lowest index) ready entry, blocked by stall or flush.
    always_comb begin
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            // Readiness includes this cycle's wakeup; operands come from wk.
            cand[i] = v_q[i] & wk[i].rdy_a & wk[i].rdy_b;
`else
            cand[i] = v_q[i] & ent_q[i].rdy_a & ent_q[i].rdy_b;
`endif
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        issue = sel_found & ~freeze_back & ~flush;
        // Wakeup only touches not-ready sources, so for an entry that was
        // already ready the woken view equals the stored one.
        sel_ent = wk[sel_idx];
    end

    // Next queue state: remove the issued entry, shift younger ones down,
    // append the dispatched entry behind the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && (i >= int'(sel_idx))) begin
                v_d[i]   = v_q[i+1];
                ent_d[i] = wk[i+1];
            end else begin
                v_d[i]   = v_q[i];
                ent_d[i] = wk[i];
            end
        end
        v_d[DEPTH-1]   = issue ? 1'b0 : v_q[DEPTH-1];
        ent_d[DEPTH-1] = wk[DEPTH-1];

        wr_idx = count_q - CNT_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (wr_idx == CNT_W'(i))) begin
                v_d[i]   = 1'b1;
                ent_d[i] = disp_ent;
            end
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(issue);

        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end
    end

    // Queue valid bits and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage.
    // NOTE: payload has no reset; the valid bits alone decide whether an
    // entry means anything, which keeps reset off the wide storage array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    // Issue register toward the add unit: load on select, hold on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_add   <= 1'b0;
            Pw_add      <= '0;
            busA_add    <= '0;
            busB_add    <= '0;
            tag_ROB_add <= '0;
        end else if (flush) begin
            valid_add <= 1'b0;
        end else if (!freeze_back) begin
            valid_add <= issue;
            if (issue) begin
                Pw_add      <= sel_ent.pw;
                busA_add    <= sel_ent.val_a;
                busB_add    <= sel_ent.val_b;
                tag_ROB_add <= sel_ent.tag;
            end
        end
    end

endmodule

// File: tb/tb_rs_add.sv
// tb_rs_add: directed, self-checking bench for rs_add (DEPTH=4).
// Per-cycle vectors cover basic issue, wakeup ordering and dispatch-time CDB
// bypass; hand-written sequences cover full/drop, flush, freeze and
// asynchronous reset. Outputs are sampled 1 ns after the rising edge.

`timescale 1ns/1ps

module tb_rs_add;

`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        freeze_back;
    logic        valid_dispatch;
    logic [4:0]  Pw_dispatch;
    logic [4:0]  Pa_dispatch;
    logic [4:0]  Pb_dispatch;
    logic        rdyA_dispatch;
    logic        rdyB_dispatch;
    logic [15:0] valA_dispatch;
    logic [15:0] valB_dispatch;
    logic [3:0]  tag_ROB_dispatch;
    logic        full_rs;
    logic        valid_cdb;
    logic [4:0]  Pw_cdb;
    logic [15:0] data_cdb;
    logic        valid_add;
    logic [4:0]  Pw_add;
    logic [15:0] busA_add;
    logic [15:0] busB_add;
    logic [3:0]  tag_ROB_add;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        fl, fz, vd;
        logic [4:0]  pw, pa, pb;
        logic        ra, rb;
        logic [15:0] va, vb;
        logic [3:0]  tg;
        logic        vc;
        logic [4:0]  pc;
        logic [15:0] dc;
        logic        ev;
        logic [4:0]  epw;
        logic [15:0] ea, eb;
        logic [3:0]  et;
        logic        ef;
    } vec_t;

    vec_t tbl[$];

    rs_add #(
        .DEPTH (4),
        .DATA_W(16),
        .PREG_W(5),
        .ROB_W (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .freeze_back     (freeze_back),
        .valid_dispatch  (valid_dispatch),
        .Pw_dispatch     (Pw_dispatch),
        .Pa_dispatch     (Pa_dispatch),
        .Pb_dispatch     (Pb_dispatch),
        .rdyA_dispatch   (rdyA_dispatch),
        .rdyB_dispatch   (rdyB_dispatch),
        .valA_dispatch   (valA_dispatch),
        .valB_dispatch   (valB_dispatch),
        .tag_ROB_dispatch(tag_ROB_dispatch),
        .full_rs         (full_rs),
        .valid_cdb       (valid_cdb),
        .Pw_cdb          (Pw_cdb),
        .data_cdb        (data_cdb),
        .valid_add       (valid_add),
        .Pw_add          (Pw_add),
        .busA_add        (busA_add),
        .busB_add        (busB_add),
        .tag_ROB_add     (tag_ROB_add)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_vf(input string n, input logic ev, input logic ef);
        check({n, ".valid_add"}, valid_add, ev);
        check({n, ".full_rs"},   full_rs,   ef);
    endtask

    task automatic expect_out(input string n, input logic ev, input logic [4:0] epw,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic [3:0] et, input logic ef);
        expect_vf(n, ev, ef);
        check({n, ".Pw_add"},      Pw_add,      epw);
        check({n, ".busA_add"},    busA_add,    ea);
        check({n, ".busB_add"},    busB_add,    eb);
        check({n, ".tag_ROB_add"}, tag_ROB_add, et);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush            = 1'b0;
        freeze_back      = 1'b0;
        valid_dispatch   = 1'b0;
        Pw_dispatch      = '0;
        Pa_dispatch      = '0;
        Pb_dispatch      = '0;
        rdyA_dispatch    = 1'b0;
        rdyB_dispatch    = 1'b0;
        valA_dispatch    = '0;
        valB_dispatch    = '0;
        tag_ROB_dispatch = '0;
        valid_cdb        = 1'b0;
        Pw_cdb           = '0;
        data_cdb         = '0;
    endtask

    task automatic disp(input logic [4:0] pw, input logic [4:0] pa, input logic [4:0] pb,
                        input logic ra, input logic rb,
                        input logic [15:0] va, input logic [15:0] vb, input logic [3:0] tg);
        valid_dispatch   = 1'b1;
        Pw_dispatch      = pw;
        Pa_dispatch      = pa;
        Pb_dispatch      = pb;
        rdyA_dispatch    = ra;
        rdyB_dispatch    = rb;
        valA_dispatch    = va;
        valB_dispatch    = vb;
        tag_ROB_dispatch = tg;
    endtask

    task automatic cdb(input logic [4:0] pc, input logic [15:0] dc);
        valid_cdb = 1'b1;
        Pw_cdb    = pc;
        data_cdb  = dc;
    endtask

    function automatic vec_t mk(
        input logic fl, input logic fz, input logic vd,
        input logic [4:0] pw, input logic [4:0] pa, input logic [4:0] pb,
        input logic ra, input logic rb,
        input logic [15:0] va, input logic [15:0] vb, input logic [3:0] tg,
        input logic vc, input logic [4:0] pc, input logic [15:0] dc,
        input logic ev, input logic [4:0] epw, input logic [15:0] ea,
        input logic [15:0] eb, input logic [3:0] et, input logic ef);
        vec_t r;
        r.fl = fl;  r.fz = fz;  r.vd = vd;
        r.pw = pw;  r.pa = pa;  r.pb = pb;
        r.ra = ra;  r.rb = rb;  r.va = va;  r.vb = vb;  r.tg = tg;
        r.vc = vc;  r.pc = pc;  r.dc = dc;
        r.ev = ev;  r.epw = epw; r.ea = ea; r.eb = eb; r.et = et; r.ef = ef;
        return r;
    endfunction

    task automatic apply(input vec_t r);
        flush            = r.fl;
        freeze_back      = r.fz;
        valid_dispatch   = r.vd;
        Pw_dispatch      = r.pw;
        Pa_dispatch      = r.pa;
        Pb_dispatch      = r.pb;
        rdyA_dispatch    = r.ra;
        rdyB_dispatch    = r.rb;
        valA_dispatch    = r.va;
        valB_dispatch    = r.vb;
        tag_ROB_dispatch = r.tg;
        valid_cdb        = r.vc;
        Pw_cdb           = r.pc;
        data_cdb         = r.dc;
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        #1;
        expect_out("reset", 1'b0, 5'd0, 16'h0, 16'h0, 4'd0, 1'b0);
        #11 rst = 1'b1;

        // ---- per-cycle vectors: inputs during the cycle, outputs after its edge
        //        fl fz vd  pw     pa     pb     ra rb  va        vb       tg     vc pc     dc         ev  epw    ea        eb       et     ef
        // ready dispatch: present next cycle, issued the cycle after
        tbl.push_back(mk(0, 0, 1, 5'd3,  5'd0,  5'd0,  1, 1, 16'h0010, 16'h0020, 4'd2, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 16'h0000, 4'd0, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 1, 5'd3, 16'h0010, 16'h0020, 4'd2, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 0, 5'd3, 16'h0010, 16'h0020, 4'd2, 0));
        // older waiting entry (tag 1, Pa=7), younger ready entry (tag 2) overtakes it
        tbl.push_back(mk(0, 0, 1, 5'd4,  5'd7,  5'd0,  0, 1, 16'h0000, 16'h0005, 4'd1, 0, 5'd0, 16'h0000, 0, 5'd3, 16'h0010, 16'h0020, 4'd2, 0));
        tbl.push_back(mk(0, 0, 1, 5'd5,  5'd0,  5'd0,  1, 1, 16'h0100, 16'h0200, 4'd2, 0, 5'd0, 16'h0000, 0, 5'd3, 16'h0010, 16'h0020, 4'd2, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 1, 5'd5, 16'h0100, 16'h0200, 4'd2, 0));
        // CDB for P7: tag 1 issues 2 cycles later (1 with wakeup bypass)
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 1, 5'd7, 16'h1234,
                         BYP, BYP ? 5'd4 : 5'd5, BYP ? 16'h1234 : 16'h0100, BYP ? 16'h0005 : 16'h0200, BYP ? 4'd1 : 4'd2, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, !BYP, 5'd4, 16'h1234, 16'h0005, 4'd1, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 0, 5'd4, 16'h1234, 16'h0005, 4'd1, 0));
        // dispatch with Pa=9 while CDB broadcasts P9: stored ready with 0xBEEF
        tbl.push_back(mk(0, 0, 1, 5'd6,  5'd9,  5'd2,  0, 1, 16'hDEAD, 16'h0001, 4'd3, 1, 5'd9, 16'hBEEF, 0, 5'd4, 16'h1234, 16'h0005, 4'd1, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 1, 5'd6, 16'hBEEF, 16'h0001, 4'd3, 0));
        tbl.push_back(mk(0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 16'h0000, 16'h0000, 4'd0, 0, 5'd0, 16'h0000, 0, 5'd6, 16'hBEEF, 16'h0001, 4'd3, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
            step();
            expect_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].epw, tbl[k].ea,
                       tbl[k].eb, tbl[k].et, tbl[k].ef);
        end

        // ---- fill with four waiting entries (tags 4..7, Pa=20..23)
        for (int i = 0; i < 4; i++) begin
            set_idle();
            disp(5'(10 + i), 5'(20 + i), 5'd0, 1'b0, 1'b1, 16'h0000, 16'(i), 4'(4 + i));
            step();
            expect_vf($sformatf("fill%0d", i), 1'b0, (i == 3));
        end
        // fifth dispatch is dropped while full
        set_idle();
        disp(5'd15, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0055, 16'h0066, 4'd9);
        step();
        expect_vf("drop", 1'b0, 1'b1);
        // wake tag 6 (Pa=22); dispatch attempts are dropped while full_rs is still high
        set_idle();
        disp(5'd16, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0077, 16'h0088, 4'd10);
        cdb(5'd22, 16'h00AA);
        step();
`ifdef RS_WAKEUP_BYPASS_EN
        expect_out("wake_issue", 1'b1, 5'd12, 16'h00AA, 16'h0002, 4'd6, 1'b0);
`else
        expect_out("wake", 1'b0, 5'd6, 16'hBEEF, 16'h0001, 4'd3, 1'b1);
        set_idle();
        disp(5'd16, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0077, 16'h0088, 4'd10);
        step();
        expect_out("wake_issue", 1'b1, 5'd12, 16'h00AA, 16'h0002, 4'd6, 1'b0);
`endif
        // the freed slot accepts a dispatch one cycle after the issue
        set_idle();
        disp(5'd17, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0011, 16'h0022, 4'd11);
        step();
        expect_out("refill", 1'b0, 5'd12, 16'h00AA, 16'h0002, 4'd6, 1'b1);
        set_idle();
        step();
        expect_out("refill_issue", 1'b1, 5'd17, 16'h0011, 16'h0022, 4'd11, 1'b0);

        // ---- flush with 3 waiting entries and a valid issue register;
        // flush beats freeze_back and a same-cycle dispatch
        set_idle();
        flush       = 1'b1;
        freeze_back = 1'b1;
        disp(5'd18, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0033, 16'h0044, 4'd12);
        cdb(5'd20, 16'h0099);
        step();
        expect_vf("flush", 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            set_idle();
            cdb((j == 0) ? 5'd21 : ((j == 1) ? 5'd23 : 5'd20), 16'h0099);
            step();
            expect_vf($sformatf("post_flush%0d", j), 1'b0, 1'b0);
        end

        // ---- freeze_back for 3 cycles with a valid issue register
        set_idle();
        disp(5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0808, 16'h0909, 4'd12);
        step();
        expect_vf("frz_p", 1'b0, 1'b0);
        set_idle();
        disp(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0A01, 16'h0B01, 4'd13);
        step();
        expect_out("frz_issue_p", 1'b1, 5'd8, 16'h0808, 16'h0909, 4'd12, 1'b0);
        set_idle();
        freeze_back = 1'b1;
        disp(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 16'h0A02, 16'h0B02, 4'd14);
        step();
        expect_out("frz1", 1'b1, 5'd8, 16'h0808, 16'h0909, 4'd12, 1'b0);
        set_idle();
        freeze_back = 1'b1;
        disp(5'd3, 5'd25, 5'd0, 1'b0, 1'b1, 16'h0000, 16'h0B03, 4'd15);
        step();
        expect_out("frz2", 1'b1, 5'd8, 16'h0808, 16'h0909, 4'd12, 1'b0);
        set_idle();
        freeze_back = 1'b1;
        cdb(5'd25, 16'h0C03);
        step();
        expect_out("frz3", 1'b1, 5'd8, 16'h0808, 16'h0909, 4'd12, 1'b0);
        set_idle();
        step();
        expect_out("rel_a", 1'b1, 5'd1, 16'h0A01, 16'h0B01, 4'd13, 1'b0);
        step();
        expect_out("rel_b", 1'b1, 5'd2, 16'h0A02, 16'h0B02, 4'd14, 1'b0);
        step();
        expect_out("rel_c", 1'b1, 5'd3, 16'h0C03, 16'h0B03, 4'd15, 1'b0);
        step();
        expect_out("rel_idle", 1'b0, 5'd3, 16'h0C03, 16'h0B03, 4'd15, 1'b0);

        // ---- asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) begin
            set_idle();
            disp(5'(20 + i), 5'd30, 5'd0, 1'b0, 1'b1, 16'h0000, 16'h0001, 4'(i));
            step();
        end
        check("refill_full.full_rs", full_rs, 1'b1);
        set_idle();
        #2 rst = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 5'd0, 16'h0, 16'h0, 4'd0, 1'b0);
        #1 rst = 1'b1;
        step();
        expect_out("post_rst", 1'b0, 5'd0, 16'h0, 16'h0, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
